// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : shared op/state encodings and constants for the RV32M unit
// Revision   : 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } muldiv_state_e;

   localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_step : one combinational shift-add / restoring shift-subtract step
// Revision    : 1.0
// ---------------------------------------------------------------------------
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    is_div,
   input  logic [2*DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0]   operand,
   output logic [2*DATA_WIDTH-1:0] acc_next
);

   logic [DATA_WIDTH:0] sum;
   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] diff;

   // Multiply: acc = {partial high, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
   always_comb begin
      acc_next = acc;
      sum      = '0;
      shifted  = '0;
      diff     = '0;
      if (is_div) begin
         shifted = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
         diff    = shifted - {1'b0, operand};
         if (!diff[DATA_WIDTH])
            acc_next = {diff[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
         else
            acc_next = {shifted[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
      end else begin
         sum      = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + {1'b0, (acc[0] ? operand : {DATA_WIDTH{1'b0}})};
         acc_next = {sum, acc[DATA_WIDTH-1:1]};
      end
   end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_sequencer : iterative RV32M multiply/divide with pipeline stall FSM
// Revision         : 1.0
// ---------------------------------------------------------------------------
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  StartE_i,
   input  logic [2:0]            MulDivOpE_i,
   input  logic [DATA_WIDTH-1:0] SrcAE_i,
   input  logic [DATA_WIDTH-1:0] SrcBE_i,
   input  logic                  FlushE_i,
   output logic                  StallE_o,
   output logic                  Busy_o,
   output logic                  ResultValid_o,
   output logic [DATA_WIDTH-1:0] Result_o
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   muldiv_state_e           state, state_next;
   logic [CNT_W-1:0]        count;
   muldiv_op_e              op_q;
   logic [DATA_WIDTH-1:0]   mag_a, mag_b;
   logic                    neg_q, neg_r;
   logic [2*DATA_WIDTH-1:0] acc, acc_next;
   logic [DATA_WIDTH-1:0]   result;

   // Accept-time decode of the incoming instruction
   muldiv_op_e              op_in;
   logic                    accept, is_div_in, signed_a_in, signed_b_in;
   logic                    neg_a_in, neg_b_in, div_zero, div_ovf, special;
   logic [DATA_WIDTH-1:0]   mag_a_in, mag_b_in, special_res;

   always_comb begin
      op_in       = muldiv_op_e'(MulDivOpE_i);
      accept      = StartE_i & ~FlushE_i;
      is_div_in   = MulDivOpE_i[2];
      signed_a_in = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
      signed_b_in = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
      neg_a_in    = signed_a_in & SrcAE_i[DATA_WIDTH-1];
      neg_b_in    = signed_b_in & SrcBE_i[DATA_WIDTH-1];
      mag_a_in    = neg_a_in ? -SrcAE_i : SrcAE_i;
      mag_b_in    = neg_b_in ? -SrcBE_i : SrcBE_i;
      div_zero    = (SrcBE_i == '0);
      div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (SrcAE_i == DATA_WIDTH'(SIGNED_MIN)) && (SrcBE_i == '1);
      special     = is_div_in & (div_zero | div_ovf);
      special_res = '0;
      if (div_zero)
         special_res = MulDivOpE_i[1] ? SrcAE_i : DATA_WIDTH'(DIV_ZERO_Q);
      else if (div_ovf)
         special_res = MulDivOpE_i[1] ? '0 : DATA_WIDTH'(SIGNED_MIN);
   end

   muldiv_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .is_div   (op_q[2]),
      .acc      (acc),
      .operand  (op_q[2] ? mag_b : mag_a),
      .acc_next (acc_next)
   );

   // Sign fix-up applied to the last step's output, captured on entry to DONE
   logic [2*DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0]   quot, rem, final_res;

   always_comb begin
      prod      = neg_q ? -acc_next : acc_next;
      quot      = neg_q ? -acc_next[DATA_WIDTH-1:0] : acc_next[DATA_WIDTH-1:0];
      rem       = neg_r ? -acc_next[2*DATA_WIDTH-1:DATA_WIDTH]
                        : acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
      final_res = '0;
      case (op_q)
         OP_MUL:                        final_res = prod[DATA_WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
         OP_DIV, OP_DIVU:               final_res = quot;
         OP_REM, OP_REMU:               final_res = rem;
         default:                       final_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      StallE_o   = 1'b0;
      case (state)
         S_IDLE: begin
            StallE_o = accept;
            if (accept) begin
               if (special)        state_next = S_DONE;
               else if (is_div_in) state_next = S_DIV;
               else                state_next = S_MUL;
            end
         end
         S_MUL, S_DIV: begin
            StallE_o = 1'b1;
            if (FlushE_i)               state_next = S_IDLE;
            else if (count == CNT_LAST) state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         op_q   <= OP_MUL;
         mag_a  <= '0;
         mag_b  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         acc    <= '0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q  <= op_in;
                  mag_a <= mag_a_in;
                  mag_b <= mag_b_in;
                  neg_q <= neg_a_in ^ neg_b_in;
                  neg_r <= neg_a_in;
                  count <= '0;
                  acc   <= is_div_in ? {{DATA_WIDTH{1'b0}}, mag_a_in}
                                     : {{DATA_WIDTH{1'b0}}, mag_b_in};
                  if (special) result <= special_res;
               end
            end
            S_MUL, S_DIV: begin
               if (FlushE_i) begin
                  count <= '0;
               end else begin
                  acc <= acc_next;
                  if (count == CNT_LAST) begin
                     count  <= '0;
                     result <= final_res;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign Busy_o        = (state != S_IDLE);
   assign ResultValid_o = (state == S_DONE);
   assign Result_o      = result;

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic        stall, busy, valid;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer #(.DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .StartE_i      (start),
      .MulDivOpE_i   (op),
      .SrcAE_i       (src_a),
      .SrcBE_i       (src_b),
      .FlushE_i      (flush),
      .StallE_o      (stall),
      .Busy_o        (busy),
      .ResultValid_o (valid),
      .Result_o      (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, hold it while stalled, count stall cycles, scramble operands mid-flight
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
      int          stalls = 0;
      logic        got = 1'b0;
      logic [31:0] res = '0;
      @(negedge clk);
      op = f3; src_a = a; src_b = b; start = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         #1;
         if (valid) begin
            got = 1'b1;
            res = result;
         end else begin
            if (stall) stalls++;
            @(negedge clk);
            if (i == 0) begin
               src_a = $urandom;
               src_b = $urandom;
            end
         end
      end
      start = 1'b0;
      check({tag, ".done"}, {31'd0, got}, 32'd1);
      check({tag, ".res"}, res, exp);
      check({tag, ".stalls"}, stalls, exp_stalls);
      @(negedge clk);
      #1;
      check({tag, ".after"}, {30'd0, busy, valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic seen;
      #12;
      check("rst.stall",  {31'd0, stall}, 32'd0);
      check("rst.busy",   {31'd0, busy},  32'd0);
      check("rst.valid",  {31'd0, valid}, 32'd0);
      check("rst.result", result,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
      run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
      run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
      run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
      run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
      run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,         1);
      run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
      run_op("rem0",   3'b110, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, 1);
      run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // Flush at iteration 10 of a divide
      @(negedge clk);
      op = 3'b100; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
      repeat (11) @(negedge clk);
      #1;
      check("flush.busy_before", {31'd0, busy}, 32'd1);
      start = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush.busy_after", {31'd0, busy}, 32'd0);
      seen = valid;
      repeat (40) begin
         @(negedge clk);
         seen = seen | valid;
      end
      check("flush.novalid", {31'd0, seen}, 32'd0);
      run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

      // Asynchronous reset at iteration 20 of a multiply, between edges
      @(negedge clk);
      op = 3'b000; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
      repeat (21) @(negedge clk);
      start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.stall",  {31'd0, stall}, 32'd0);
      check("arst.busy",   {31'd0, busy},  32'd0);
      check("arst.valid",  {31'd0, valid}, 32'd0);
      check("arst.result", result,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("mul_after_rst", 3'b000, 32'd5, 32'd6, 32'd30, 33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_muldiv_sequencer
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own control FSM, placed beside the ALU in the execute stage.
- Accepts forwarded operands when an M-extension instruction reaches execute.
- Holds the pipeline via a stall output while it iterates one bit per cycle.
- Presents a one-cycle result that execute muxes onto its ALU result path.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- StartE_i  in  1  valid M-extension instruction present in execute
- MulDivOpE_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE_i  in  DATA_WIDTH  forwarded rs1 value
- SrcBE_i  in  DATA_WIDTH  forwarded rs2 value
- FlushE_i  in  1  kill the in-flight operation
- StallE_o  out  1  to hazard unit: hold fetch/decode/execute
- Busy_o  out  1  FSM not IDLE
- ResultValid_o  out  1  Result_o valid this cycle
- Result_o  out  DATA_WIDTH  final result

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, counter 0, all internal registers 0, StallE_o 0, Busy_o 0, ResultValid_o 0, Result_o 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - StallE_o = StartE_i & ~FlushE_i, combinational, so the instruction is held from its first execute cycle.
  - On StartE_i & ~FlushE_i, latch op, operand magnitudes and sign flags.
  - Go to MUL (op[2]=0) or DIV (op[2]=1).
  - Special case: divisor zero, or signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF, op DIV/REM), goes directly to DONE with the result precomputed.
- MUL:
  - Shift-add, one multiplier bit per cycle into a 2*DATA_WIDTH accumulator.
  - Counter runs 0..DATA_WIDTH-1; at DATA_WIDTH-1, go to DONE. StallE_o = 1.
- DIV:
  - Restoring shift-subtract, one quotient bit per cycle; same counter rule. StallE_o = 1.
- DONE:
  - ResultValid_o = 1, StallE_o = 0, so the instruction advances into memory this cycle.
  - StartE_i is ignored (it is still the same instruction). Next state is always IDLE.
- Latency: normal op stalls 1 + DATA_WIDTH cycles (33), then the result is valid in DONE. Special-case divide stalls 1 cycle.
- Signedness:
  - Operands are converted to magnitudes at accept.
  - MULH: both signed. MULHSU: A signed, B unsigned. MULHU, DIVU, REMU: unsigned.
  - Product is negated (64-bit two's complement) if the sign flags differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU); remainder = dividend unmodified.
- Overflow: DIV returns 0x80000000; REM returns 0.
- Result_o:
  - Registered, updated on entry to DONE.
  - Holds its value after DONE; only ResultValid_o qualifies it.
- Flush:
  - FlushE_i in MUL/DIV: next state IDLE, no ResultValid_o, counter cleared.
  - FlushE_i in IDLE blocks acceptance.
  - FlushE_i in DONE is ignored (the result has already retired into memory).
- Reset mid-operation: immediate asynchronous return to IDLE with all outputs cleared. No partial result is ever flagged valid.
- Operands are sampled only at accept; input changes during MUL/DIV have no effect.
- Busy_o = (state != IDLE).

Decomposition:
- Shared package muldiv_pkg:
  - funct3 op encoding enum (MUL..REMU).
  - FSM state enum.
  - Constants DIV_ZERO_Q (all ones) and SIGNED_MIN (0x80000000).
- One natural sub-module: muldiv_step.
  - Combinational single iteration.
  - Multiply: conditional add and shift.
  - Divide: trial subtract, select, shift in quotient bit.
  - Instanced once; the FSM sequences it.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> StallE_o high 33 cycles, then ResultValid_o for 1 cycle with Result_o = 0xFFFFFFEB; Busy_o low on the following cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each with exactly 1 stall cycle. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; 1 stall cycle.
- Start DIV, assert FlushE_i at iteration 10 -> IDLE next cycle, ResultValid_o never asserts. A new MUL 3 x 4 started afterwards -> 12.
- Deassert rst_n at iteration 20 of a MUL, between clock edges -> all outputs 0 immediately. Release and re-issue the op -> correct result after 33 stall cycles.
